// File: rtl/spi_ram_pkg.sv
// Shared frame/command definitions for the SPI slave and the RAM controller behind it.
// Both blocks decode frame bits [9:8] through this package.
package spi_ram_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic [1:0] frame_cmd(logic [FRAME_W-1:0] frame);
    return frame[FRAME_W-1 -: 2];
  endfunction

  function automatic logic [DATA_W-1:0] frame_payload(logic [FRAME_W-1:0] frame);
    return frame[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Frame/response bundle between the SPI slave (master side) and the RAM controller.
interface spi_ram_ctrl_if
  import spi_ram_pkg::*;
  ;
  logic [FRAME_W-1:0] din;
  logic               rx_valid;
  logic [DATA_W-1:0]  dout;
  logic               tx_valid;
  logic               cmd_err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  cmd_err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output cmd_err
  );

endinterface

// File: rtl/spi_ram_array.sv
// Single-port synchronous RAM: registered read-first output, storage never reset.
module spi_ram_array
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder + RAM behind the SPI slave: address/data frames in, read bytes out.
// Independent write and read pointers, each gated by its own valid flag.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input logic           clk,
  input logic           rst,
  spi_ram_ctrl_if.slave bus
);

  logic [1:0]           cmd;
  logic [DATA_W-1:0]    payload;

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_vld_q, wr_addr_vld_d;
  logic                 rd_addr_vld_q, rd_addr_vld_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [DATA_W-1:0]    dout_hold_q, dout_hold_d;

  logic                 ram_wr;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_rdata;

  assign cmd     = frame_cmd(bus.din);
  assign payload = frame_payload(bus.din);

  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    tx_valid_d    = 1'b0;
    cmd_err_d     = 1'b0;
    ram_wr        = 1'b0;
    ram_addr      = wr_addr_q;
    // Latch the byte being shown so dout keeps it once the RAM output moves on.
    dout_hold_d   = tx_valid_q ? ram_rdata : dout_hold_q;

    if (bus.rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d     = payload[ADDR_SIZE-1:0];
          wr_addr_vld_d = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_addr_vld_q) begin
            ram_wr    = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d     = payload[ADDR_SIZE-1:0];
          rd_addr_vld_d = 1'b1;
        end
        CMD_RD_DATA: begin
          ram_addr = rd_addr_q;
          if (rd_addr_vld_q) begin
            tx_valid_d = 1'b1;
            rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // A write coinciding with reset must not reach the array.
  assign ram_we = ram_wr & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      dout_hold_q   <= '0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      tx_valid_q    <= tx_valid_d;
      cmd_err_q     <= cmd_err_d;
      dout_hold_q   <= dout_hold_d;
    end
  end

  spi_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  assign bus.dout     = tx_valid_q ? ram_rdata : dout_hold_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port RAM plus command decoder directly downstream of the SPI slave.
- Consumes the 10-bit frames the slave produces on its rx_data / rx_valid pair.
- Returns read bytes to the slave's serialiser on its tx_data / tx_valid pair.
- Frame bits [9:8] select the command; bits [7:0] carry an address or data payload.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words in the array; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width in bits; the address payload uses din[ADDR_SIZE-1:0].

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  10  frame from SPI slave; [9:8] is the command, [7:0] is the payload.
- rx_valid  input  1  din is valid this cycle; one frame is consumed per cycle when high.
- dout  output  8  read data to SPI slave.
- tx_valid  output  1  dout is valid; one-cycle pulse per read-data command.
- cmd_err  output  1  one-cycle pulse when a data command arrives with no address set.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - dout=0, tx_valid=0, cmd_err=0.
  - wr_addr=0, rd_addr=0, wr_addr_vld=0, rd_addr_vld=0.
  - Memory contents are not cleared by reset; they are undefined at power-up.
- Commands are sampled only on an edge where rx_valid=1. With rx_valid=0 nothing changes except that tx_valid and cmd_err return to 0.
- 2'b00 WR_ADDR: wr_addr <= din[7:0]; wr_addr_vld <= 1. No memory access.
- 2'b01 WR_DATA:
  - If wr_addr_vld=1: mem[wr_addr] <= din[7:0] on that edge; wr_addr <= wr_addr+1, wrapping modulo MEM_DEPTH (0xFF -> 0x00).
  - If wr_addr_vld=0: the write is dropped and cmd_err pulses for 1 cycle.
- 2'b10 RD_ADDR: rd_addr <= din[7:0]; rd_addr_vld <= 1.
- 2'b11 RD_DATA:
  - If rd_addr_vld=1: dout <= mem[rd_addr] and tx_valid <= 1 on that edge, so the data is visible in the cycle after acceptance (latency 1). rd_addr <= rd_addr+1 with the same wrap rule. The din[7:0] payload is ignored.
  - If rd_addr_vld=0: dout holds its value, tx_valid stays 0, and cmd_err pulses.
- tx_valid is high for exactly one cycle per accepted RD_DATA. On back-to-back RD_DATA it stays high and dout steps through sequential addresses.
- dout holds its last value when tx_valid=0.
- Read-after-write to the same address on the next cycle returns the new data. The write commits on the earlier edge; there is no bypass path.
- The write and read address registers are independent; setting one never changes the other.
- Reset asserted mid-stream:
  - Any pending tx_valid is killed and the address-valid flags clear.
  - The next data command then errors until a new address is sent.
  - A WR_DATA in the same cycle as rst is not written.
- There is no FSM beyond the two valid flags; the block accepts any command order.

Decomposition:
- Shared package spi_ram_pkg:
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Frame width 10 and data width 8.
  - The SPI slave uses the same package so both blocks decode [9:8] identically.
- One sub-module, spi_ram_array: single-port synchronous RAM with ports clk, we, addr, wdata, rdata.
  - Registered read, no reset on storage.
  - Read and write share one address port. The controller muxes wr_addr or rd_addr onto it according to the command.

Test Plan:
- Reset then RD_DATA (din=10'b11_0000_0000) -> cmd_err=1 for one cycle, tx_valid=0, dout=0x00.
- Write and read back:
  - Stimulus: WR_ADDR 10'b00_1101_1101, WR_DATA 10'b01_1010_1010, RD_ADDR 10'b10_1101_1101, RD_DATA.
  - Response: one cycle after RD_DATA, tx_valid=1 and dout=0xAA.
- Address wrap:
  - Stimulus: WR_ADDR 0xFF, then WR_DATA 0x11 and WR_DATA 0x22 on consecutive cycles; RD_ADDR 0xFF, then two back-to-back RD_DATA.
  - Response: tx_valid high for 2 consecutive cycles with dout=0x11 then 0x22, confirming the 0x22 write landed at 0x00.
- Interleaved addressing:
  - Stimulus: WR_ADDR 0x10, RD_ADDR 0x20, WR_DATA 0x5A, RD_ADDR 0x10, RD_DATA.
  - Response: dout=0x5A, and the read address register did not disturb the write address register.
- rx_valid gating: din=10'b01_1111_1111 with rx_valid=0 -> a later read of that location returns its previous value, and cmd_err never pulses.
- Reset mid-stream:
  - Stimulus: WR_ADDR 0x40, assert rst for 1 cycle, then WR_DATA 0x77.
  - Response: cmd_err pulses and mem[0x40] is unchanged; after reset, WR_ADDR 0x40 plus WR_DATA 0x77 succeeds and reads back 0x77.
